// File: rtl/sevenseg_pkg.sv
// Shared constants, buffer type and hex decode for the seven-segment scanner.
// Leading-zero blanking is selected by SEVENSEG_LZB_EN.
package sevenseg_pkg;

    localparam int MAX_DIGITS = 16;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] value;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   en;
    } disp_buf_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_hex7seg.sv
// Combinational nibble to active-low gfedcba segment decoder.
// Used once by sevenseg_scan (SEVENSEG_LZB_EN has no effect here).
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nib);
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering.
// Define SEVENSEG_LZB_EN to blank leading zero digits.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 1024,
    parameter int DIM_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIM_BITS-1:0] DIM_FULL = '1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    disp_buf_t           act_q, act_d;
    disp_buf_t           pend_buf_q, pend_buf_d;
    logic                pending_q, pending_d;
    logic                frame_tick_q, frame_tick_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                dp_q, dp_d;

    disp_buf_t           in_buf;
    logic                pre_tc;
    logic                boundary;
    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic [DIM_BITS-1:0] phase;
    logic                shown;
    logic                lit;

    always_comb begin
        in_buf = '0;
        in_buf.value[4*DIGITS-1:0] = value;
        in_buf.dp[DIGITS-1:0]      = dp_in;
        in_buf.en[DIGITS-1:0]      = digit_en;
    end

    assign pre_tc   = (pre_q == PRE_LAST);
    assign boundary = pre_tc && (idx_q == IDX_LAST);

    always_comb begin
        pre_d        = pre_tc ? '0 : pre_q + 1'b1;
        idx_d        = idx_q;
        act_d        = act_q;
        pend_buf_d   = pend_buf_q;
        pending_d    = pending_q;
        frame_tick_d = boundary;
        if (pre_tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A load on the boundary itself bypasses the pending stage.
        if (load && boundary) begin
            act_d     = in_buf;
            pending_d = 1'b0;
        end else if (load) begin
            pend_buf_d = in_buf;
            pending_d  = 1'b1;
        end else if (boundary && pending_q) begin
            act_d     = pend_buf_q;
            pending_d = 1'b0;
        end
    end

    assign nib   = act_q.value[{idx_q, 2'b00} +: 4];
    assign phase = pre_q[PRE_W-1 -: DIM_BITS];

    hex7seg u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEVENSEG_LZB_EN
    logic [IDX_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (act_q.value[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign shown = (idx_q <= msd);
`else
    assign shown = 1'b1;
`endif

    assign lit = act_q.en[idx_q] && shown &&
                 ((phase < brightness) || (brightness == DIM_FULL));

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~act_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            dp_q         <= 1'b1;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomised self-checking bench for sevenseg_scan (4 digits, 16-cycle slots).
// Covers both builds of SEVENSEG_LZB_EN.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        pending;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] SEGS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    sevenseg_scan #(
        .DIGITS      (4),
        .REFRESH_DIV (16),
        .DIM_BITS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: t = cycles since reset release; slot/phase from arithmetic.
    int          t;
    logic [15:0] m_act_val, m_pen_val;
    logic [3:0]  m_act_dp, m_act_en, m_pen_dp, m_pen_en;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    int          m_slot, m_phase, m_nib, m_msd;
    bit          m_bnd, m_show, m_lit;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_act_val = '0; m_act_dp = '0; m_act_en = '0;
            m_pen_val = '0; m_pen_dp = '0; m_pen_en = '0;
            m_pend = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            m_slot  = (t / 16) % 4;
            m_phase = (t % 16) / 4;
            m_bnd   = (t % 64) == 63;
            m_nib   = int'((m_act_val >> (4 * m_slot)) & 16'hF);
            m_show  = 1;
`ifdef SEVENSEG_LZB_EN
            m_msd = 0;
            for (int i = 0; i < 4; i++)
                if (((m_act_val >> (4 * i)) & 16'hF) != 0) m_msd = i;
            m_show = (m_slot <= m_msd);
`endif
            m_lit = m_act_en[m_slot] && m_show &&
                    ((m_phase < int'(brightness)) || (brightness == 2'd3));
            if (m_lit) begin
                e_an  = ~(4'b0001 << m_slot);
                e_seg = SEGS[m_nib];
                e_dp  = ~m_act_dp[m_slot];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_tick = m_bnd;
            if (load && m_bnd) begin
                m_act_val = value; m_act_dp = dp_in; m_act_en = digit_en;
                m_pend = 0;
            end else if (load) begin
                m_pen_val = value; m_pen_dp = dp_in; m_pen_en = digit_en;
                m_pend = 1;
            end else if (m_bnd && m_pend) begin
                m_act_val = m_pen_val; m_act_dp = m_pen_dp; m_act_en = m_pen_en;
                m_pend = 0;
            end
            t++;
        end
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 ||
                pending !== 1'b0 || frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: an=%h seg=%h dp=%b pend=%b tick=%b want F 7f 1 0 0",
                         an, seg, dp, pending, frame_tick);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [6:0] exp_scan [4] = '{7'h10, 7'h30, 7'h0E, 7'h78};
        value = 16'h7F39; digit_en = 4'hF; dp_in = 4'h0; brightness = 2'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        while (t < 140) begin
            n_tests++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp ||
                pending !== m_pend || frame_tick !== e_tick) begin
                n_fail++;
                $display("FAIL scan t=%0d: an=%h seg=%h dp=%b p=%b tk=%b want %h %h %b %b %b",
                         t, an, seg, dp, pending, frame_tick,
                         e_an, e_seg, e_dp, m_pend, e_tick);
            end
            if (t == 63 || t == 64) begin
                n_tests++;
                if (pending !== (t == 63)) begin
                    n_fail++;
                    $display("FAIL scan_pending t=%0d: got %b want %b", t, pending, t == 63);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (t == 64 + 16 * i + 9) begin
                    n_tests++;
                    if (an !== ~(4'b0001 << i) || seg !== exp_scan[i]) begin
                        n_fail++;
                        $display("FAIL scan_digit%0d: an=%h seg=%h want %h %h",
                                 i, an, seg, ~(4'b0001 << i), exp_scan[i]);
                    end
                end
            end
            value = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_double_load();
        int n79 = 0, n24 = 0, nt = 0;
        for (int k = 0; k < 100 && (t % 64) != 5; k++) @(negedge clk);
        value = 16'h1111; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = 16'($urandom);
        for (int k = 0; k < 100 && (t % 64) != 20; k++) @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = 16'h1111;
        repeat (192) begin
            n_tests++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp ||
                pending !== m_pend || frame_tick !== e_tick) begin
                n_fail++;
                $display("FAIL dbl t=%0d: an=%h seg=%h dp=%b p=%b tk=%b want %h %h %b %b %b",
                         t, an, seg, dp, pending, frame_tick,
                         e_an, e_seg, e_dp, m_pend, e_tick);
            end
            if (an !== 4'hF && seg === 7'h79) n79++;
            if (an !== 4'hF && seg === 7'h24) n24++;
            if (frame_tick === 1'b1) nt++;
            @(negedge clk);
        end
        n_tests++;
        if (n79 != 0 || n24 == 0 || nt != 3) begin
            n_fail++;
            $display("FAIL dbl_summary: ones=%0d twos=%0d ticks=%0d want 0 >0 3", n79, n24, nt);
        end
    endtask

    task automatic test_brightness();
        int cnt [4] = '{0, 0, 0, 0};
        int nlit = 0;
        brightness = 2'd1;
        repeat (64) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (an[i] === 1'b0) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cnt[i] != 4) begin
                n_fail++;
                $display("FAIL bright1_an%0d: low %0d cycles want 4", i, cnt[i]);
            end
        end
        brightness = 2'd0;
        repeat (64) begin
            @(negedge clk);
            if (an !== 4'hF) nlit++;
        end
        n_tests++;
        if (nlit != 0) begin
            n_fail++;
            $display("FAIL bright0: lit %0d cycles want 0", nlit);
        end
        brightness = 2'd3;
    endtask

    task automatic test_boundary_load();
        logic [15:0] nv;
        int npend = 0;
        for (int k = 0; k < 100 && (t % 64) != 63; k++) @(negedge clk);
        n_tests++;
        if ((t % 64) != 63) begin
            n_fail++;
            $display("FAIL bnd_wait: phase %0d want 63", t % 64);
        end
        nv = 16'($urandom) | 16'h1000;
        value = nv; digit_en = 4'hF; dp_in = 4'h1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (pending === 1'b1) npend++;
        @(negedge clk);
        n_tests++;
        if (an !== 4'hE || seg !== SEGS[nv[3:0]] || dp !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_slot0: an=%h seg=%h dp=%b want e %h 0",
                     an, seg, dp, SEGS[nv[3:0]]);
        end
        repeat (80) begin
            if (pending === 1'b1) npend++;
            @(negedge clk);
        end
        n_tests++;
        if (npend != 0) begin
            n_fail++;
            $display("FAIL bnd_pending: asserted %0d cycles want 0", npend);
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        logic [3:0]  e_a;
        logic [6:0]  e_s;
        logic        e_d;
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 100 && (t % 64) != 10; k++) @(negedge clk);
            value = vals[v]; dp_in = 4'h8; digit_en = 4'hF; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int k = 0; k < 100 && (t % 64) != 0; k++) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 40 && (t % 64) != 16 * i + 9; k++) @(negedge clk);
                e_a = ~(4'b0001 << i);
                e_s = SEGS[(vals[v] >> (4 * i)) & 16'hF];
                e_d = (i == 3) ? 1'b0 : 1'b1;
`ifdef SEVENSEG_LZB_EN
                if (i > ((v == 0) ? 1 : 0)) begin
                    e_a = 4'hF; e_s = 7'h7F; e_d = 1'b1;
                end
`endif
                n_tests++;
                if (an !== e_a || seg !== e_s || dp !== e_d) begin
                    n_fail++;
                    $display("FAIL lzb v=%h d%0d: an=%h seg=%h dp=%b want %h %h %b",
                             vals[v], i, an, seg, dp, e_a, e_s, e_d);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int nbad = 0;
        for (int k = 0; k < 100 && (t % 64) != 10; k++) @(negedge clk);
        value = 16'h5A5A; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pending !== 1'b0 || an !== 4'hF || seg !== 7'h7F ||
            dp !== 1'b1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: an=%h seg=%h dp=%b p=%b tk=%b want F 7f 1 0 0",
                     an, seg, dp, pending, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (an !== 4'hF || pending !== 1'b0) nbad++;
        end
        n_tests++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL midrst_discard: %0d bad cycles want 0", nbad);
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            @(negedge clk);
            n_tests++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp ||
                pending !== m_pend || frame_tick !== e_tick) begin
                n_fail++;
                $display("FAIL rand t=%0d: an=%h seg=%h dp=%b p=%b tk=%b want %h %h %b %b %b",
                         t, an, seg, dp, pending, frame_tick,
                         e_an, e_seg, e_dp, m_pend, e_tick);
            end
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            load     = ($urandom_range(0, 19) == 0);
            if ((t % 64) == 63 && $urandom_range(0, 1) == 1) load = 1'b1;
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_load();
        test_brightness();
        test_boundary_load();
        test_lzb();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed seven-segment display controller that generalises the fixed 8-digit display path behind the board's `seg`/`an`/`dp` pins. It scans `DIGITS` hex digits at a programmable refresh rate, double-buffers display data so updates land only on frame boundaries, and supports per-digit enable, per-digit decimal point and global PWM brightness. It sits between the CPU/IO register file and the board pins.

## Interface
- `DIGITS`, 8: number of digits/anodes, 1..16.
- `REFRESH_DIV`, 1024: clock cycles per digit slot; power of two, ≥ 2^`DIM_BITS`.
- `DIM_BITS`, 4: brightness resolution.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `value` in 4*`DIGITS`: hex nibbles; nibble i drives digit i (digit 0 = rightmost).
- `dp_in` in `DIGITS`: decimal point per digit, 1 = lit.
- `digit_en` in `DIGITS`: 1 = digit shown, 0 = blanked.
- `load` in 1: one-cycle strobe; captures `value`, `dp_in`, `digit_en` into the pending buffer.
- `brightness` in `DIM_BITS`: 0 = dark, all-ones = full on.
- `seg` out 7: active-low segments {g,f,e,d,c,b,a}.
- `an` out `DIGITS`: active-low anodes, one-hot-low or all-high.
- `dp` out 1: active-low decimal point.
- `pending` out 1: pending buffer holds data not yet committed.
- `frame_tick` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler `pre` counts 0..`REFRESH_DIV`-1; at terminal count, digit index `idx` advances, modulo `DIGITS`.
- Frame boundary = `pre` terminal count with `idx` = `DIGITS`-1. On it: `frame_tick`=1 next cycle; if `pending`, pending buffer copies to active buffer and `pending` clears.
- `load`: pending buffer ← inputs, `pending` ← 1. Repeated loads before a boundary: last wins.
- `load` coinciding with the frame boundary: the loaded data commits directly to active, `pending` stays 0.
- Display never reads inputs directly; only the active buffer.
- PWM phase = top `DIM_BITS` bits of `pre`. Digit lit when `digit_en[idx]` and (phase < `brightness` or `brightness` all-ones). Else `an` all-high, `seg`=7'h7F, `dp`=1.
- Lit: `an[idx]`=0, others 1; `seg` = hex decode of active nibble; `dp` = ~active dp bit.
- Decode (active-low gfedcba): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- `brightness` sampled live (not buffered).

## Timing
- Reset: `pre`=0, `idx`=0, active and pending buffers all zero (digits disabled), `pending`=0, `frame_tick`=0, `an`=all-ones, `seg`=7'h7F, `dp`=1.
- `seg`/`an`/`dp` registered: reflect `idx`/`pre` state one cycle late; no output glitch between slots (an goes all-high or switches directly to next one-hot-low).
- `pending` rises the cycle after `load`.
- First frame boundary after reset: cycle `DIGITS`*`REFRESH_DIV`-1; `frame_tick` high the following cycle.
- `rst` mid-frame: everything returns to reset values next edge, pending data discarded.

## Configuration
- `SEVENSEG_LZB_EN` defined: leading-zero blanking — enabled digits above the most significant non-zero nibble of the active buffer are blanked (anode off, dp also off); digit 0 always shown. Value 0 shows a single "0".
- Undefined: all enabled digits shown, including leading zeros.

## Structure
- `sevenseg_pkg`: segment constants (`SEG_BLANK`=7'h7F), hex-to-segment lookup function, active buffer struct typedef.
- One sub-module: `hex7seg` (combinational nibble→segments decoder), instantiated once on the selected nibble.
- Everything else (prescaler, scan, buffers, PWM) in `sevenseg_scan`.

## Test plan
(bench: `DIGITS`=4, `REFRESH_DIV`=16, `DIM_BITS`=2)
- Reset held 3 cycles -> `an`=4'hF, `seg`=7'h7F, `dp`=1, `pending`=0 throughout.
- `load` with `value`=16'h7F39, `digit_en`=4'hF, `brightness`=3 -> `pending`=1 until cycle 63, then scan shows digit0 seg 10, digit1 30, digit2 0E, digit3 78, each for 16 cycles.
- Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 ever displayed; `frame_tick` once per 64 cycles.
- `brightness`=1 -> each anode low 4 of 16 cycles per slot; `brightness`=0 -> `an` stays 4'hF.
- `load` exactly on frame-boundary cycle -> new data shown from next slot 0, `pending` never asserts.
- `SEVENSEG_LZB_EN`, value 16'h0042, `dp_in`=4'h8 -> digits 3,2 blanked (including dp), digits 1,0 show 19, 24; value 0 -> only digit 0 shows 40.
